pcma_eq_sequencer: RTL and testbench

//  Control sequencer for the PCMA compensator equalizer. Holds a host-writable table of EQ_LEN

---
 rtl/pcma_eq_sequencer_if.sv | 53 +++++
 rtl/pcma_eq_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pcma_eq_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pcma_eq_sequencer_if.sv
// ============================================================================
// Module      : pcma_eq_sequencer_if
// Description : Host, table-write and compensator-control bundle of the
//               PCMA equalizer start-up sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pcma_eq_sequencer_if #(
  parameter int COE_WIDTH     = 16,
  parameter int INV_COE_WIDTH = 8,
  parameter int EQ_LEN        = 19,
  parameter int CNT_WIDTH     = 20
);
  localparam int FCW = COE_WIDTH + INV_COE_WIDTH;
  localparam int AW  = $clog2(EQ_LEN);

  logic                 start;
  logic                 abort;
  logic                 cfg_preset;
  logic                 cfg_track;
  logic [CNT_WIDTH-1:0] cfg_train_len;
  logic [9:0]           cfg_norm_per;
  logic                 coe_wr;
  logic [AW-1:0]        coe_waddr;
  logic [FCW-1:0]       coe_wdata;
  logic                 sym_val;
  logic                 preset_coe;
  logic                 load_coe;
  logic [FCW-1:0]       o_init_coe;
  logic                 teach_en;
  logic [9:0]           norm_per;
  logic                 busy;
  logic                 done;
  logic                 wr_err;
  logic [2:0]           state;

  modport master (
    output start, abort, cfg_preset, cfg_track, cfg_train_len, cfg_norm_per,
    output coe_wr, coe_waddr, coe_wdata, sym_val,
    input  preset_coe, load_coe, o_init_coe, teach_en, norm_per,
    input  busy, done, wr_err, state
  );

  modport slave (
    input  start, abort, cfg_preset, cfg_track, cfg_train_len, cfg_norm_per,
    input  coe_wr, coe_waddr, coe_wdata, sym_val,
    output preset_coe, load_coe, o_init_coe, teach_en, norm_per,
    output busy, done, wr_err, state
  );
endinterface

`default_nettype wire

// File: rtl/pcma_eq_sequencer.sv
// ============================================================================
// Module      : pcma_eq_sequencer
// Description : Start-up sequencer for the PCMA compensator equalizer:
//               preset or coefficient-table load, training, optional tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcma_eq_sequencer #(
  parameter int COE_WIDTH     = 16,
  parameter int INV_COE_WIDTH = 8,
  parameter int EQ_LEN        = 19,
  parameter int CNT_WIDTH     = 20
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  pcma_eq_sequencer_if.slave  bus
);
  localparam int FCW = COE_WIDTH + INV_COE_WIDTH;
  localparam int AW  = $clog2(EQ_LEN);
  localparam logic [AW:0] C_K_END = (AW+1)'(EQ_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESET = 3'd1,
    S_LOAD   = 3'd2,
    S_TRAIN  = 3'd3,
    S_TRACK  = 3'd4
  } state_t;

  state_t               r_state;
  logic [FCW-1:0]       r_table [EQ_LEN];
  logic [AW:0]          r_k;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_len;
  logic                 r_track;
  logic [9:0]           r_norm;
  logic                 r_preset;
  logic                 r_load;
  logic [FCW-1:0]       r_init;
  logic                 r_teach;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_wr_err;
  logic                 w_bad_addr;
  logic                 w_train_end;

  assign w_bad_addr  = ({1'b0, bus.coe_waddr} >= C_K_END);
  // A zero training length ends TRAIN on its first cycle without waiting for symbols.
  assign w_train_end = (r_len == '0) ||
                       (bus.sym_val && (r_cnt == (r_len - CNT_WIDTH'(1))));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_track  <= 1'b0;
      r_norm   <= '0;
      r_preset <= 1'b0;
      r_load   <= 1'b0;
      r_init   <= '0;
      r_teach  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state  <= S_IDLE;
        r_busy   <= 1'b0;
        r_preset <= 1'b0;
        r_load   <= 1'b0;
        r_init   <= '0;
        r_teach  <= 1'b0;
        r_k      <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_norm  <= bus.cfg_norm_per;
              r_len   <= bus.cfg_train_len;
              r_track <= bus.cfg_track;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              if (bus.cfg_preset) begin
                r_state  <= S_PRESET;
                r_preset <= 1'b1;
              end else begin
                r_state <= S_LOAD;
                r_load  <= 1'b1;
                r_init  <= r_table[0];
                r_k     <= (AW+1)'(1);
              end
            end
          end
          S_PRESET: begin
            r_preset <= 1'b0;
            r_state  <= S_TRAIN;
            r_cnt    <= '0;
            r_teach  <= (r_len != '0);
          end
          S_LOAD: begin
            // r_k is the index of the entry presented on the next cycle.
            if (r_k == C_K_END) begin
              r_load  <= 1'b0;
              r_init  <= '0;
              r_k     <= '0;
              r_state <= S_TRAIN;
              r_cnt   <= '0;
              r_teach <= (r_len != '0);
            end else begin
              r_init <= r_table[r_k[AW-1:0]];
              r_k    <= r_k + (AW+1)'(1);
            end
          end
          S_TRAIN: begin
            if (w_train_end) begin
              r_done <= 1'b1;
              if (r_track) begin
                r_state <= S_TRACK;
                r_teach <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_teach <= 1'b0;
                r_busy  <= 1'b0;
              end
            end else if (bus.sym_val) begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
          S_TRACK: begin
            r_teach <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Coefficient table: writes are refused while it is being streamed out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < EQ_LEN; i++) begin
        r_table[i] <= '0;
      end
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= 1'b0;
      if (bus.coe_wr) begin
        if ((r_state == S_LOAD) || w_bad_addr) begin
          r_wr_err <= 1'b1;
        end else begin
          r_table[bus.coe_waddr] <= bus.coe_wdata;
        end
      end
    end
  end

  assign bus.preset_coe = r_preset;
  assign bus.load_coe   = r_load;
  assign bus.o_init_coe = r_init;
  assign bus.teach_en   = r_teach;
  assign bus.norm_per   = r_norm;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.wr_err     = r_wr_err;
  assign bus.state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pcma_eq_sequencer.sv
// ============================================================================
// Module      : tb_pcma_eq_sequencer
// Description : Directed, table-driven self-checking bench for pcma_eq_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcma_eq_sequencer;
  localparam int EQ_LEN = 19;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  logic [23:0] tb_tab [EQ_LEN];

  typedef struct {
    logic        preset;
    logic        track;
    logic [19:0] len;
    logic [9:0]  norm;
    logic        restart;
    int          exp_load;
    int          exp_pre;
    int          exp_train;
    int          exp_teach;
    int          exp_done;
    logic [2:0]  exp_state;
  } vec_t;

  vec_t vecs [6];

  pcma_eq_sequencer_if #(.COE_WIDTH(16), .INV_COE_WIDTH(8), .EQ_LEN(EQ_LEN), .CNT_WIDTH(20)) bus ();

  pcma_eq_sequencer #(.COE_WIDTH(16), .INV_COE_WIDTH(8), .EQ_LEN(EQ_LEN), .CNT_WIDTH(20)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_run(input logic preset, input logic track, input logic [19:0] len,
                           input logic [9:0] norm);
    bus.cfg_preset    = preset;
    bus.cfg_track     = track;
    bus.cfg_train_len = len;
    bus.cfg_norm_per  = norm;
    bus.start         = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int nload, npre, ntrain, nteach, ndone, cyc, tcyc;
    bit fin;
    nload = 0; npre = 0; ntrain = 0; nteach = 0; ndone = 0; cyc = 0; tcyc = 0; fin = 0;
    start_run(v.preset, v.track, v.len, v.norm);
    check($sformatf("v%0d_busy", idx), 32'(bus.busy), 32'd1);
    check($sformatf("v%0d_norm_start", idx), 32'(bus.norm_per), 32'(v.norm));
    while (!fin && cyc < 100) begin
      bus.start = 1'b0;
      bus.cfg_norm_per = v.norm;
      if (bus.load_coe) begin
        if (nload < EQ_LEN) check($sformatf("v%0d_load_data%0d", idx, nload),
                                  32'(bus.o_init_coe), 32'(tb_tab[nload]));
        nload++;
      end else if (bus.o_init_coe !== 24'd0) begin
        check($sformatf("v%0d_init_zero", idx), 32'(bus.o_init_coe), 32'd0);
      end
      if (bus.preset_coe) npre++;
      if (bus.done) ndone++;
      if (bus.state == 3'd3) begin
        ntrain++;
        if (bus.teach_en) nteach++;
        bus.sym_val = ((tcyc % 2) == 0);
        if (v.restart && tcyc == 0) begin
          bus.start        = 1'b1;
          bus.cfg_norm_per = ~v.norm;
        end
        tcyc++;
      end else begin
        bus.sym_val = 1'b0;
      end
      if (bus.done || bus.state == 3'd0) fin = 1;
      else begin
        step();
        cyc++;
      end
    end
    bus.sym_val = 1'b0;
    bus.start   = 1'b0;
    if (!fin) check($sformatf("v%0d_timeout", idx), 32'd0, 32'd1);
    check($sformatf("v%0d_nload", idx), 32'(nload), 32'(v.exp_load));
    check($sformatf("v%0d_npreset", idx), 32'(npre), 32'(v.exp_pre));
    check($sformatf("v%0d_ntrain", idx), 32'(ntrain), 32'(v.exp_train));
    check($sformatf("v%0d_nteach", idx), 32'(nteach), 32'(v.exp_teach));
    check($sformatf("v%0d_ndone", idx), 32'(ndone), 32'(v.exp_done));
    check($sformatf("v%0d_state", idx), 32'(bus.state), 32'(v.exp_state));
    check($sformatf("v%0d_teach_end", idx), 32'(bus.teach_en), 32'(v.exp_state == 3'd4));
    check($sformatf("v%0d_norm_hold", idx), 32'(bus.norm_per), 32'(v.norm));
    step();
    check($sformatf("v%0d_done_width", idx), 32'(bus.done), 32'd0);
    if (v.exp_state == 3'd4) begin
      check($sformatf("v%0d_track_teach", idx), 32'(bus.teach_en), 32'd1);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check($sformatf("v%0d_track_start_ign", idx), 32'(bus.state), 32'd4);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check($sformatf("v%0d_abort_teach", idx), 32'(bus.teach_en), 32'd0);
      check($sformatf("v%0d_abort_state", idx), 32'(bus.state), 32'd0);
      check($sformatf("v%0d_abort_done", idx), 32'(bus.done), 32'd0);
      check($sformatf("v%0d_abort_busy", idx), 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    //              pre  trk  len     norm    rst  load pre train teach done state
    vecs[0] = '{1'b0, 1'b0, 20'd4, 10'h155, 1'b0, 19, 0, 7, 7, 1, 3'd0};
    vecs[1] = '{1'b1, 1'b0, 20'd0, 10'h003, 1'b0,  0, 1, 1, 0, 1, 3'd0};
    vecs[2] = '{1'b1, 1'b1, 20'd2, 10'h3FF, 1'b0,  0, 1, 3, 3, 1, 3'd4};
    vecs[3] = '{1'b0, 1'b1, 20'd1, 10'h0AA, 1'b0, 19, 0, 1, 1, 1, 3'd4};
    vecs[4] = '{1'b0, 1'b0, 20'd0, 10'h001, 1'b0, 19, 0, 1, 0, 1, 3'd0};
    vecs[5] = '{1'b1, 1'b0, 20'd3, 10'h2C3, 1'b1,  0, 1, 5, 5, 1, 3'd0};

    reset_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_preset = 1'b0; bus.cfg_track = 1'b0;
    bus.cfg_train_len = '0; bus.cfg_norm_per = '0; bus.coe_wr = 1'b0; bus.coe_waddr = '0;
    bus.coe_wdata = '0; bus.sym_val = 1'b0;
    step();
    step();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_outputs", 32'({bus.preset_coe, bus.load_coe, bus.teach_en, bus.busy, bus.done, bus.wr_err}), 32'd0);
    check("rst_init_norm", 32'({bus.o_init_coe, bus.norm_per}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    for (int k = 0; k < EQ_LEN; k++) begin
      bus.coe_wr = 1'b1; bus.coe_waddr = 5'(k); bus.coe_wdata = 24'(k + 1);
      tb_tab[k] = 24'(k + 1);
      step();
      check($sformatf("wr_ok%0d", k), 32'(bus.wr_err), 32'd0);
    end
    bus.coe_waddr = 5'd19; bus.coe_wdata = 24'hBADBAD;
    step();
    bus.coe_wr = 1'b0;
    check("wr_err_badaddr", 32'(bus.wr_err), 32'd1);
    step();
    check("wr_err_pulse", 32'(bus.wr_err), 32'd0);

    // Load aborted at k=10 with a write attempted during the load
    start_run(1'b0, 1'b0, 20'd4, 10'h0F0);
    for (int i = 0; i <= 10; i++) begin
      check($sformatf("ab_load_data%0d", i), 32'(bus.o_init_coe), 32'(tb_tab[i]));
      if (i == 0) begin
        bus.coe_wr = 1'b1; bus.coe_waddr = 5'd3; bus.coe_wdata = 24'hABCDEF;
      end else bus.coe_wr = 1'b0;
      if (i == 1) check("wr_err_load", 32'(bus.wr_err), 32'd1);
      if (i == 10) bus.abort = 1'b1;
      step();
    end
    bus.abort = 1'b0;
    check("ab_load_coe", 32'(bus.load_coe), 32'd0);
    check("ab_state", 32'(bus.state), 32'd0);
    check("ab_done", 32'(bus.done), 32'd0);
    step();
    check("ab_done_later", 32'(bus.done), 32'd0);

    bus.start = 1'b1; bus.abort = 1'b1; bus.cfg_norm_per = 10'h123;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_state", 32'(bus.state), 32'd0);
    check("start_abort_norm", 32'(bus.norm_per), 32'h0F0);

    for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

    // Asynchronous reset in the middle of a load
    start_run(1'b0, 1'b0, 20'd4, 10'h077);
    for (int i = 0; i < 7; i++) step();
    check("mid_k7_data", 32'(bus.o_init_coe), 32'(tb_tab[7]));
    reset_n = 1'b0;
    #1;
    check("mid_rst_load", 32'(bus.load_coe), 32'd0);
    check("mid_rst_init", 32'(bus.o_init_coe), 32'd0);
    check("mid_rst_state", 32'(bus.state), 32'd0);
    check("mid_rst_norm", 32'(bus.norm_per), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < EQ_LEN; k++) tb_tab[k] = 24'd0;
    step();
    run_vec(vecs[4], 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
